// File: rtl/nfc_rb_monitor.sv
// NAND R/B- monitor: per-way synchroniser, glitch filter, edge pulses and sticky busy timeout.
// Raw-to-oReadyBusy latency is SyncStages+FilterCycles edges; status-only block with no flow control.
module nfc_rb_monitor #(
  parameter int NumberOfWays = 4,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4,
  parameter int TimeoutWidth = 20
) (
  input  logic                    iSystemClock,
  input  logic                    iModuleResetN,
  input  logic [NumberOfWays-1:0] iRBFromPad,
  input  logic [TimeoutWidth-1:0] iTimeoutLimit,
  input  logic [NumberOfWays-1:0] iTimeoutClear,
  output logic [NumberOfWays-1:0] oReadyBusy,
  output logic [NumberOfWays-1:0] oReadyRise,
  output logic [NumberOfWays-1:0] oBusyFall,
  output logic [NumberOfWays-1:0] oTimeout,
  output logic                    oAllReady
);

  localparam int FW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [FW-1:0]           FiltLast = FW'(FilterCycles - 1);
  localparam logic [TimeoutWidth-1:0] CntOne   = TimeoutWidth'(1);

  typedef enum logic [1:0] {
    ST_READY   = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  for (genvar w = 0; w < NumberOfWays; w++) begin : g_way
    logic [SyncStages-1:0]   sync_q;
    logic                    sync_s;
    logic [FW-1:0]           filt_q, filt_d;
    logic                    ready_q, ready_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    state_e                  state_q;
    logic [TimeoutWidth-1:0] cnt_q;
    logic                    timeout_q;
    logic                    limit_hit;
    logic                    tmo_set;

    always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
      if (!iModuleResetN) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SyncStages-2:0], iRBFromPad[w]};
      end
    end

    assign sync_s = sync_q[SyncStages-1];

    // Any edge where the synchronised level agrees with the output restarts the stability count.
    always_comb begin
      filt_d  = '0;
      ready_d = ready_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_s != ready_q) begin
        if (filt_q == FiltLast) begin
          ready_d = sync_s;
          rise_d  = sync_s;
          fall_d  = ~sync_s;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
      if (!iModuleResetN) begin
        filt_q  <= '0;
        ready_q <= 1'b1;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        filt_q  <= filt_d;
        ready_q <= ready_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Equality against the live limit: lowering it below the count never fires.
    assign limit_hit = (iTimeoutLimit != '0) && (cnt_q == iTimeoutLimit);
    assign tmo_set   = (state_q == ST_BUSY) && limit_hit;

    always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
      if (!iModuleResetN) begin
        state_q   <= ST_READY;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (tmo_set) begin
          timeout_q <= 1'b1;
        end else if (iTimeoutClear[w]) begin
          timeout_q <= 1'b0;
        end
        case (state_q)
          ST_READY: begin
            if (fall_d) begin
              state_q <= ST_BUSY;
              cnt_q   <= CntOne;
            end
          end
          ST_BUSY, ST_TIMEOUT: begin
            if (rise_d) begin
              state_q <= ST_READY;
              cnt_q   <= '0;
            end else begin
              if (tmo_set) begin
                state_q <= ST_TIMEOUT;
              end
              cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CntOne;
            end
          end
          default: begin
            state_q <= ST_READY;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign oReadyBusy[w] = ready_q;
    assign oReadyRise[w] = rise_q;
    assign oBusyFall[w]  = fall_q;
    assign oTimeout[w]   = timeout_q;
  end

  assign oAllReady = &oReadyBusy;

endmodule
